// File: rtl/audio_sample_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : audio_sample_scheduler_if
//  Purpose  : Bundles the configuration, mixer and PCM output handshake
//             signals of the audio sample scheduler.
//  Modports : slave  - the scheduler itself
//             master - the surrounding system (or a testbench)
//  Signals  : enable_i, sample_div_i       sample-rate control
//             cfg_write_i/enable_i/gain_i  staged mixer configuration
//             cfg_pending_o                staged config not yet applied
//             wave_step_o                  oscillator advance pulse
//             mix_enable_o, mix_gain_o     active mixer configuration
//             mixed_wave_i                 mixer output
//             sample_o/valid_o/ready_i     PCM16 output handshake
//             overrun_o, overrun_clear_i   sticky overrun flag
//             busy_o                       sequence in progress
//  Revision : 1.0  initial release
// ============================================================================
interface audio_sample_scheduler_if #(
    parameter int DIV_WIDTH = 16
);
    logic                 enable_i;
    logic [DIV_WIDTH-1:0] sample_div_i;
    logic                 cfg_write_i;
    logic [3:0]           cfg_enable_i;
    logic [63:0]          cfg_gain_i;
    logic                 cfg_pending_o;
    logic                 wave_step_o;
    logic [3:0]           mix_enable_o;
    logic [63:0]          mix_gain_o;
    logic [15:0]          mixed_wave_i;
    logic [15:0]          sample_o;
    logic                 sample_valid_o;
    logic                 sample_ready_i;
    logic                 overrun_o;
    logic                 overrun_clear_i;
    logic                 busy_o;

    modport slave (
        input  enable_i, sample_div_i, cfg_write_i, cfg_enable_i, cfg_gain_i,
               mixed_wave_i, sample_ready_i, overrun_clear_i,
        output cfg_pending_o, wave_step_o, mix_enable_o, mix_gain_o,
               sample_o, sample_valid_o, overrun_o, busy_o
    );

    modport master (
        output enable_i, sample_div_i, cfg_write_i, cfg_enable_i, cfg_gain_i,
               mixed_wave_i, sample_ready_i, overrun_clear_i,
        input  cfg_pending_o, wave_step_o, mix_enable_o, mix_gain_o,
               sample_o, sample_valid_o, overrun_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/audio_sample_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : audio_sample_scheduler
//  Purpose  : Sample-rate sequencer for the audio mixer. Generates the
//             per-sample tick, pulses the oscillators, applies staged
//             enable/gain configuration only on sample boundaries, captures
//             the settled mixer output into a valid/ready register and flags
//             overruns.
//  Ports    : clk_i  - system clock
//             rst_i  - synchronous active-high reset
//             bus    - audio_sample_scheduler_if.slave (all other signals)
//  Revision : 1.0  initial release
// ============================================================================
module audio_sample_scheduler #(
    parameter int MIXER_LATENCY = 2,
    parameter int DIV_WIDTH     = 16
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    audio_sample_scheduler_if.slave bus
);

    localparam int SW = (MIXER_LATENCY > 1) ? $clog2(MIXER_LATENCY) : 1;
    localparam logic [SW-1:0] c_SETTLE_LAST = SW'(MIXER_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STEP    = 2'd1,
        S_SETTLE  = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t               r_state;
    logic [SW-1:0]        r_settle_cnt;
    logic [DIV_WIDTH-1:0] r_div_cnt;

    logic [3:0]  r_stage_en;
    logic [63:0] r_stage_gain;
    logic        r_pending;
    logic        r_wave_step;
    logic [3:0]  r_mix_en;
    logic [63:0] r_mix_gain;
    logic [15:0] r_sample;
    logic        r_valid;
    logic        r_overrun;
    logic        r_busy;

    logic w_tick;
    logic w_accept;
    logic w_slot_free;
    logic w_apply;
    logic w_ovr_set;

    assign w_tick      = bus.enable_i && (r_div_cnt == '0);
    assign w_accept    = r_valid && bus.sample_ready_i;
    assign w_slot_free = !r_valid || w_accept;
    // Staged config reaches the mixer only between samples: on the tick that
    // starts a new sample, or immediately while the scheduler is stopped.
    assign w_apply     = (r_state == S_IDLE) && r_pending && (w_tick || !bus.enable_i);
    // A tick that lands mid-sequence is dropped; a capture with the output
    // slot still occupied loses its sample. Both are reported as overruns.
    assign w_ovr_set   = (w_tick && (r_state != S_IDLE)) ||
                         ((r_state == S_CAPTURE) && !w_slot_free);

    // Sample-period divider: held at the reload value while stopped so the
    // first tick after enabling arrives a full period later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_div_cnt <= '0;
        end else if (!bus.enable_i || (r_div_cnt == '0)) begin
            r_div_cnt <= bus.sample_div_i;
        end else begin
            r_div_cnt <= r_div_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_stage_en   <= '0;
            r_stage_gain <= '0;
            r_pending    <= 1'b0;
            r_wave_step  <= 1'b0;
            r_mix_en     <= '0;
            r_mix_gain   <= '0;
            r_sample     <= '0;
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_wave_step <= 1'b0;

            // A write coinciding with the apply edge stays pending: the apply
            // copies the old staging contents while the new ones are loaded.
            if (bus.cfg_write_i) begin
                r_stage_en   <= bus.cfg_enable_i;
                r_stage_gain <= bus.cfg_gain_i;
                r_pending    <= 1'b1;
            end else if (w_apply) begin
                r_pending    <= 1'b0;
            end

            if (w_apply) begin
                r_mix_en   <= r_stage_en;
                r_mix_gain <= r_stage_gain;
            end

            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (bus.overrun_clear_i) begin
                r_overrun <= 1'b0;
            end

            if (w_accept) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state     <= S_STEP;
                        r_wave_step <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_STEP: begin
                    r_state      <= S_SETTLE;
                    r_settle_cnt <= c_SETTLE_LAST;
                end
                S_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (w_slot_free) begin
                        r_sample <= bus.mixed_wave_i;
                        r_valid  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_pending_o  = r_pending;
    assign bus.wave_step_o    = r_wave_step;
    assign bus.mix_enable_o   = r_mix_en;
    assign bus.mix_gain_o     = r_mix_gain;
    assign bus.sample_o       = r_sample;
    assign bus.sample_valid_o = r_valid;
    assign bus.overrun_o      = r_overrun;
    assign bus.busy_o         = r_busy;

endmodule
`default_nettype wire

// File: doc/audio_sample_scheduler.md
# audio_sample_scheduler

Sequencer that drives the audio mixer at the PCM sample rate inside the Audio Synthesis Unit. It generates the per-sample tick, pulses the oscillators to advance one sample, and applies staged enable/gain configuration only on sample boundaries, so mid-sample gain changes cannot glitch the output. After the mixer pipeline settles it captures the mixed sample into a valid/ready output register feeding the APU output buffer, and flags overruns.

## Interface
- MIXER_LATENCY, 2, clock edges from stable mixer inputs to valid `mixed_wave_i`
- DIV_WIDTH, 16, width of sample period divider
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- enable_i  in  1  run sample scheduling
- sample_div_i  in  DIV_WIDTH  sample period minus one, in clk_i cycles
- cfg_write_i  in  1  load staging config
- cfg_enable_i  in  4  staged enables {sine, square, triangle, custom}
- cfg_gain_i  in  64  staged Q1.15 gains {sine[63:48], square, triangle, custom[15:0]}
- cfg_pending_o  out  1  staged config not yet applied
- wave_step_o  out  1  one-cycle pulse: oscillators advance one sample
- mix_enable_o  out  4  active enables to mixer, same order as cfg_enable_i
- mix_gain_o  out  64  active gains to mixer, same packing as cfg_gain_i
- mixed_wave_i  in  16  mixer output
- sample_o  out  16  captured PCM16 sample
- sample_valid_o  out  1  sample_o valid
- sample_ready_i  in  1  consumer accepts sample
- overrun_o  out  1  sticky overrun flag
- overrun_clear_i  in  1  clear overrun_o
- busy_o  out  1  FSM not IDLE

## Operation
- Divider: while enable_i=0, counter reloads sample_div_i each cycle. While enable_i=1, it decrements; at 0 it raises tick for one cycle and reloads sample_div_i. Period = sample_div_i+1 cycles.
- FSM states:
  - IDLE: on tick go to STEP; if cfg_pending_o, copy staging into mix_enable_o/mix_gain_o on the same edge and clear pending.
  - STEP: exactly 1 cycle, wave_step_o=1, then SETTLE.
  - SETTLE: MIXER_LATENCY cycles, then CAPTURE.
  - CAPTURE: 1 cycle, then IDLE. On exit edge, if output slot is free or accepted this cycle (sample_valid_o & sample_ready_i), load sample_o from mixed_wave_i and set sample_valid_o; otherwise discard the new sample and set overrun_o.
- Output handshake: sample_o stable while sample_valid_o=1 and not accepted. Valid drops the cycle after acceptance unless reloaded on that same edge.
- Overrun also sets on a tick outside IDLE; that tick is ignored. Set wins over overrun_clear_i in the same cycle.
- Config staging: cfg_write_i loads staging and sets cfg_pending_o next cycle. Later writes overwrite staging. A write on the apply edge is kept and remains pending for the next sample. If enable_i=0 and FSM is IDLE, pending config applies on the next edge.
- enable_i deasserted mid-sequence: sequence completes normally; no further ticks.
- Requirement: sample_div_i ≥ MIXER_LATENCY+2. Smaller values yield overruns, never corruption.

## Timing
- Reset values: all outputs 0, counter 0, FSM IDLE, staging 0. Reset mid-sequence aborts to IDLE and drops any held sample.
- Tick in cycle T → STEP (wave_step_o=1) in T+1 → SETTLE T+2..T+1+MIXER_LATENCY → CAPTURE T+2+MIXER_LATENCY → sample_valid_o=1 from T+3+MIXER_LATENCY. Default: valid at T+5.
- New config is visible on mix_* in cycle T+1, one edge before the oscillators advance.
- busy_o=1 from T+1 through CAPTURE inclusive.

## Test plan
- Steady run: sample_div_i=47, ready tied 1, sine only, gain 0x7FFF → wave_step_o every 48 cycles; sample_valid_o 4 cycles after each step pulse; sample_o equals mixed_wave_i sampled in CAPTURE; overrun_o stays 0.
- Boundary config: write gain 0x4000 mid-sample → mix_gain_o unchanged until the cycle after the next tick; cfg_pending_o 1→0 on that edge; no mid-sample change.
- Backpressure: ready held 0 for 2 sample periods → first sample held stable; second capture discarded; overrun_o=1; overrun_clear_i clears it only in a cycle with no new overrun.
- Accept in capture cycle: ready asserted exactly in CAPTURE with valid pending → new sample loaded; no overrun.
- Short period: sample_div_i=2 → ticks during SETTLE flagged as overrun; each emitted sample still completes the full sequence.
- Reset mid-SETTLE and disabled apply: rst_i pulse → all outputs 0 next cycle, FSM IDLE. With enable_i=0, a cfg_write_i applies to mix_* within 2 cycles.
